fp_sum_squares: RTL and testbench

FP_SUM_SQUARES -- requirements
Module: fp_sum_squares

---
 rtl/math_pkg.sv | 17 +
 rtl/fp_seq_square.sv | 60 ++++++
 rtl/fp_sum_squares.sv | 103 ++++++++++
 tb/tb_fp_sum_squares.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/math_pkg.sv
// Shared definitions for the fixed-point sum-of-squares datapath.
//   state_e    : control states of fp_sum_squares
//   cnt_width(): width of a bit counter that runs 0..width-1
package math_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } state_e;

  // Width of a counter that must hold the values 0..width-1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fp_seq_square.sv
// Sequential shift-add squarer: one multiplier bit per clock.
//   clk, reset : clock, asynchronous active-low reset
//   start      : load operand, clear product, begin WIDTH steps
//   operand    : value to square, sampled only when start is high
//   busy       : high while more steps remain after the current one;
//                low during the final step so the controller can leave
//                its multiply state on the same edge the last step lands
//   product    : 2*WIDTH-bit result, final one cycle after busy drops
module fp_seq_square
  import math_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     operand,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   product
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_product;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_run;

  // NOTE: every register here is a plain flop, so all of them take the
  // asynchronous reset; only true memory arrays would be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcand   <= '0;
      r_product <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_run     <= 1'b0;
    end else if (start) begin
      r_mcand   <= {{WIDTH{1'b0}}, operand};
      r_mplier  <= operand;
      r_product <= '0;
      r_cnt     <= '0;
      r_run     <= 1'b1;
    end else if (r_run) begin
      // NOTE: non-blocking assignments make every update read the values
      // from before this edge, so the add and both shifts stay in step.
      if (r_mplier[0]) r_product <= r_product + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == LAST) r_run <= 1'b0;
      else               r_cnt <= r_cnt + 1'b1;
    end
  end

  assign busy    = r_run && (r_cnt != LAST);
  assign product = r_product;

endmodule

// File: rtl/fp_sum_squares.sv
// Running saturated sum of squares of unsigned fixed-point samples.
//   clk, reset : clock, asynchronous active-low reset
//   go         : accept one sample (only in IDLE)
//   in         : sample, read only on the accepting edge
//   clear      : zero accumulator and overflow flag (only in IDLE)
//   out        : registered saturated sum; feeds fp_sqrt
//   done       : one-cycle pulse when out reflects the latest sample
//   ovf        : sticky saturation flag
// All outputs come straight from flops.
module fp_sum_squares
  import math_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] in,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             ovf
);

  if (WIDTH != INT_WIDTH + FRAC_WIDTH) begin : g_bad_format
    $error("fp_sum_squares: WIDTH must equal INT_WIDTH + FRAC_WIDTH");
  end

  state_e               r_state;
  state_e               w_next;
  logic                 w_start;
  logic                 w_busy;
  logic [2*WIDTH-1:0]   w_product;
  logic [2*WIDTH-1:0]   w_shifted;
  logic [WIDTH-1:0]     w_sq;
  logic [WIDTH:0]       w_sum;
  logic                 w_sat;
  logic [WIDTH-1:0]     r_acc;
  logic                 r_done;
  logic                 r_ovf;

  assign w_start = (r_state == IDLE) && go;

  fp_seq_square #(.WIDTH(WIDTH)) u_square (
    .clk     (clk),
    .reset   (reset),
    .start   (w_start),
    .operand (in),
    .busy    (w_busy),
    .product (w_product)
  );

  // Square in the sample's own format: drop FRAC_WIDTH fraction bits.
  // Anything left above WIDTH bits means the square alone overflows.
  assign w_shifted = w_product >> FRAC_WIDTH;
  assign w_sq      = w_shifted[WIDTH-1:0];
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_sq};
  assign w_sat     = r_ovf || (|w_shifted[2*WIDTH-1:WIDTH]) || w_sum[WIDTH];

  always_comb begin
    // NOTE: the default assignment first means every path through the
    // case drives w_next, so no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (go) w_next = MUL;
      MUL:     if (!w_busy) w_next = ACC;
      ACC:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ACC);
      // clear with go in IDLE zeroes here; the accepted sample lands
      // on this zeroed value when ACC comes round.
      if (r_state == IDLE && clear) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (r_state == ACC) begin
        if (w_sat) begin
          r_acc <= '1;
          r_ovf <= 1'b1;
        end else begin
          r_acc <= w_sum[WIDTH-1:0];
        end
      end
    end
  end

  assign out  = r_acc;
  assign done = r_done;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_fp_sum_squares.sv
// Self-checking bench for fp_sum_squares (WIDTH=32, 16.16 format).
// Reference model: 64-bit integer arithmetic on the sample values.
module tb_fp_sum_squares;

  localparam int              W    = 32;
  localparam int              FRAC = 16;
  localparam longint unsigned MAX  = 64'h0000_0000_FFFF_FFFF;

  logic          clk;
  logic          reset;
  logic          go;
  logic [W-1:0]  in;
  logic          clear;
  logic [W-1:0]  out;
  logic          done;
  logic          ovf;

  int n_vec;
  int n_miss;

  longint unsigned m_acc;
  bit              m_ovf;

  fp_sum_squares #(.WIDTH(W), .INT_WIDTH(16), .FRAC_WIDTH(FRAC)) dut (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .in    (in),
    .clear (clear),
    .out   (out),
    .done  (done),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic [W-1:0] x, input bit clr);
    longint unsigned xx;
    longint unsigned sq;
    if (clr) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end
    xx = 64'(x);
    sq = (xx * xx) >> FRAC;
    if (m_ovf || sq > MAX || m_acc + sq > MAX) begin
      m_acc = MAX;
      m_ovf = 1'b1;
    end else begin
      m_acc = m_acc + sq;
    end
  endtask

  // Drives go right away (caller is just past an edge, possibly in the
  // done cycle of the previous sample) and ends inside the done cycle.
  task automatic do_op(input logic [W-1:0] x, input bit clr, input bit noise, input string tag);
    bit early;
    go = 1'b1; in = x; clear = clr;
    @(posedge clk); #1;
    go = 1'b0; clear = 1'b0; in = $urandom;
    model_step(x, clr);
    early = done;
    for (int i = 1; i <= W + 1; i++) begin
      if (noise) begin
        go = 1'($urandom); clear = 1'($urandom); in = $urandom;
      end
      @(posedge clk); #1;
      if (i <= W && done) early = 1'b1;
    end
    go = 1'b0; clear = 1'b0;
    check({tag, "_early_done"}, {31'd0, early}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_out"}, out, m_acc[W-1:0]);
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, m_ovf});
  endtask

  task automatic idle(input int n);
    go = 1'b0; clear = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) check("done_drop", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    bit seen;
    logic [W-1:0] x;
    n_vec = 0; n_miss = 0;
    m_acc = 0; m_ovf = 1'b0;
    reset = 1'b0; go = 1'b0; clear = 1'b0; in = '0;

    #2;
    check("rst_out",  out, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf",  {31'd0, ovf}, 32'd0);
    #10 reset = 1'b1;

    // First accept on the first edge after release, then back-to-back.
    do_op(32'h0003_0000, 1'b0, 1'b0, "sq3");
    do_op(32'h0004_0000, 1'b0, 1'b0, "sq4_b2b");
    idle(2);

    // Saturation, then stickiness.
    do_op(32'h0100_0000, 1'b0, 1'b0, "sat");
    idle(1);
    do_op(32'h0001_0000, 1'b0, 1'b0, "sat_sticky");
    idle(1);

    // Clear alone in IDLE.
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    m_acc = 0; m_ovf = 1'b0;
    check("clr_out",  out, 32'd0);
    check("clr_ovf",  {31'd0, ovf}, 32'd0);
    check("clr_done", {31'd0, done}, 32'd0);

    // Saturate again, then clear together with go.
    do_op(32'hFFFF_FFFF, 1'b0, 1'b0, "sat2");
    idle(1);
    do_op(32'h0000_8000, 1'b1, 1'b0, "clr_go");
    idle(1);

    // go/in/clear noise during MUL and ACC.
    do_op(32'h0001_8000, 1'b0, 1'b1, "noise");
    idle(1);

    // Reset in the middle of a multiply.
    go = 1'b1; in = 32'h0005_0000;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mrst_out",  out, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    check("mrst_ovf",  {31'd0, ovf}, 32'd0);
    m_acc = 0; m_ovf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < W + 5; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("mrst_no_done", {31'd0, seen}, 32'd0);
    do_op(32'h0002_0000, 1'b0, 1'b0, "after_rst");

    // Randomized samples against the model.
    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 3))
        0:       x = $urandom;
        1:       x = 32'($urandom_range(0, 32'h0003_FFFF));
        2:       x = 32'($urandom_range(0, 32'h00FF_FFFF));
        default: x = 32'($urandom_range(0, 32'h0000_FFFF));
      endcase
      do_op(x, ($urandom_range(0, 3) == 0), 1'($urandom), $sformatf("rnd%0d", k));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
